serv_ibus_bytefetch: RTL
========================

// Module: serv_ibus_bytefetch
// PURPOSE
//  Wishbone instruction-bus responder that answers the core's ibus fetches
//  (cyc/adr, returns rdt/ack) from a byte-wide synchronous memory.
//  Reads 4 bytes little-endian, assembles the 32-bit word and acks once.
//  Sits between the core's ibus master and a narrow boot ROM/flash.
//  The acked word is what the instruction decoder samples.
// PARAMETERS
//  AW       32  byte-address width of the memory port (>=3)
//  MEM_LAT  1   memory read latency in cycles, legal 1..3
// PORTS
//  clk             in   1   clock, all logic on rising edge
//  i_rst           in   1   asynchronous, active-high reset
//  i_wb_ibus_adr   in   32  fetch address; bits [1:0] ignored
//  i_wb_ibus_cyc   in   1   fetch request, held until ack
//  o_wb_ibus_rdt   out  32  fetched instruction word
//  o_wb_ibus_ack   out  1   one-cycle fetch complete strobe
//  o_mem_adr       out  AW  byte address to memory
//  o_mem_re        out  1   memory read strobe, one cycle per byte
//  i_mem_rdata     in   8   memory read data, valid MEM_LAT cycles after o_mem_re
//  o_busy          out  1   high while a fetch is in progress (not IDLE)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; rdt=0, ack=0, re=0,
//    mem_adr=0, busy=0, byte count=0, latency count=0. All outputs registered.
//  - States: IDLE, REQ, WAIT, ACK.
//  - IDLE: if cyc & !ack -> latch adr[AW-1:2] as base, cnt=0, go REQ.
//  - REQ: re=1 for exactly this cycle, mem_adr={base,cnt}; load lat=MEM_LAT;
//    go WAIT.
//  - WAIT: decrement lat; on the edge where data is valid (MEM_LAT cycles
//    after REQ) capture i_mem_rdata into rdt[8*cnt+:8]. If cnt==3 go ACK,
//    else cnt+=1 and go REQ. No overlapping requests.
//  - ACK: ack=1 for one cycle, rdt stable and complete; next state IDLE.
//    rdt holds its value until the next byte capture.
//  - Latency: cyc first sampled high at cycle 0 -> ack at cycle
//    4*(MEM_LAT+1)+1 (9 for MEM_LAT=1). One IDLE cycle between fetches.
//  - Fetch address changes while busy are ignored (base latched in IDLE).
//  - Abort: cyc low in REQ or WAIT -> IDLE next cycle, no ack, no further
//    re; partially written rdt bytes are don't-care; re is never asserted
//    in the abort cycle's successor.
//  - cyc low in ACK: ack still issued (already committed).
//  - Byte count wraps only via IDLE reset to 0; cnt never exceeds 3.
//  - mem_adr holds its last value when re=0.
//  - Reset mid-fetch: immediate return to reset values, no ack.
//  - Byte order: byte at base+0 -> rdt[7:0], base+3 -> rdt[31:24].
// TESTING
//  - Reset then cyc=1, adr=0x100, mem bytes 13,05,00,00 at 0x100..0x103,
//    MEM_LAT=1 -> re at 0x100..0x103, ack at cycle 9, rdt=0x00000513.
//  - adr=0x203 (low bits set) -> mem_adr sequence 0x200..0x203.
//  - Back-to-back fetches 0x0 then 0x4 -> two acks, exactly one IDLE
//    cycle between ack and next re, rdt matches each word.
//  - cyc dropped after second byte -> no ack, no further re, busy low
//    next cycle; next fetch of 0x10 returns correct word.
//  - i_rst pulsed during WAIT (async, mid-cycle) -> outputs zero
//    immediately, no ack; fetch after release completes normally.
//  - MEM_LAT=3 build: ack at cycle 17, data sampled 3 cycles after each re.

Source files
------------

// File: rtl/serv_ibus_bytefetch.sv
// Wishbone ibus responder: gathers four bytes from a byte-wide synchronous
// memory (little-endian) and returns them as one 32-bit instruction word.
module serv_ibus_bytefetch #(
  parameter int AW      = 32,  // 3..32
  parameter int MEM_LAT = 1    // 1..3
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic [31:0]   i_wb_ibus_adr,
  input  logic          i_wb_ibus_cyc,
  output logic [31:0]   o_wb_ibus_rdt,
  output logic          o_wb_ibus_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic          o_mem_re,
  input  logic [7:0]    i_mem_rdata,
  output logic          o_busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT);

  state_t        state, state_n;
  logic [AW-3:0] base, base_n;
  logic [1:0]    cnt, cnt_n;
  logic [1:0]    lat, lat_n;
  logic [31:0]   rdt_n;
  logic          ack_n, re_n, busy_n;
  logic [AW-1:0] mem_adr_n;

  // Word-aligned fetch: the low address bits only matter to the core.
  logic unused_adr;
  assign unused_adr = ^i_wb_ibus_adr;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      base          <= '0;
      cnt           <= 2'd0;
      lat           <= 2'd0;
      o_wb_ibus_rdt <= 32'd0;
      o_wb_ibus_ack <= 1'b0;
      o_mem_re      <= 1'b0;
      o_mem_adr     <= '0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_n;
      base          <= base_n;
      cnt           <= cnt_n;
      lat           <= lat_n;
      o_wb_ibus_rdt <= rdt_n;
      o_wb_ibus_ack <= ack_n;
      o_mem_re      <= re_n;
      o_mem_adr     <= mem_adr_n;
      o_busy        <= busy_n;
    end
  end

  // Outputs are registered, so re/ack/adr are computed for the state being entered.
  always_comb begin
    state_n   = state;
    base_n    = base;
    cnt_n     = cnt;
    lat_n     = lat;
    rdt_n     = o_wb_ibus_rdt;
    ack_n     = 1'b0;
    re_n      = 1'b0;
    mem_adr_n = o_mem_adr;

    unique case (state)
      IDLE: begin
        if (i_wb_ibus_cyc && !o_wb_ibus_ack) begin
          base_n    = i_wb_ibus_adr[AW-1:2];
          cnt_n     = 2'd0;
          re_n      = 1'b1;
          mem_adr_n = {i_wb_ibus_adr[AW-1:2], 2'b00};
          state_n   = REQ;
        end
      end

      REQ: begin
        if (!i_wb_ibus_cyc) begin
          state_n = IDLE;
        end else begin
          lat_n   = LAT_LOAD;
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (!i_wb_ibus_cyc) begin
          state_n = IDLE;
        end else begin
          lat_n = lat - 2'd1;
          if (lat == 2'd1) begin
            unique case (cnt)
              2'd0: rdt_n[7:0]   = i_mem_rdata;
              2'd1: rdt_n[15:8]  = i_mem_rdata;
              2'd2: rdt_n[23:16] = i_mem_rdata;
              2'd3: rdt_n[31:24] = i_mem_rdata;
              default: ;
            endcase
            if (cnt == 2'd3) begin
              ack_n   = 1'b1;
              state_n = ACK;
            end else begin
              cnt_n     = cnt + 2'd1;
              re_n      = 1'b1;
              mem_adr_n = {base, cnt + 2'd1};
              state_n   = REQ;
            end
          end
        end
      end

      ACK: begin
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
